// File: rtl/axis_demux_1to2_if.sv
// AXI-Stream beat bundle shared by the demux input and both outputs.
// master drives data/valid/last, slave returns ready.
interface axis_demux_1to2_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              last;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );
endinterface

// File: rtl/axis_demux_1to2.sv
// 1-to-2 AXI-Stream demux with per-packet route lock, registered
// one-entry output slots and wrapping completed-packet counters.
module axis_demux_1to2 #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    axis_demux_1to2_if.slave    s_axis,
    input  logic                sel,
    axis_demux_1to2_if.master   m_axis_1,
    axis_demux_1to2_if.master   m_axis_2,
    output logic                busy,
    output logic [CNT_W-1:0]    pkt_cnt_1,
    output logic [CNT_W-1:0]    pkt_cnt_2
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK1 = 2'd1;
    localparam logic [1:0] LOCK2 = 2'd2;

    logic [1:0]        state_q;
    logic              tgt;
    logic              accept;
    logic              ld_1;
    logic              ld_2;

    logic              v_1;
    logic              l_1;
    logic [DATA_W-1:0] d_1;
    logic              v_2;
    logic              l_2;
    logic [DATA_W-1:0] d_2;

    // tgt: 0 selects output 1, 1 selects output 2
    always_comb begin
        tgt = sel;
        unique case (1'b1)
            (state_q == LOCK1): tgt = 1'b0;
            (state_q == LOCK2): tgt = 1'b1;
            default:            tgt = sel;
        endcase
    end

    // a slot can take a beat if empty or draining this cycle
    assign s_axis.ready = reset_n &&
                          (tgt ? (!v_2 || m_axis_2.ready)
                               : (!v_1 || m_axis_1.ready));

    assign accept = s_axis.valid && s_axis.ready;
    assign ld_1   = accept && !tgt;
    assign ld_2   = accept &&  tgt;

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else if (accept) begin
            if (s_axis.last) begin
                state_q <= IDLE;
            end else if (state_q == IDLE) begin
                state_q <= tgt ? LOCK2 : LOCK1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_1 <= 1'b0;
            l_1 <= 1'b0;
            d_1 <= '0;
        end else if (ld_1) begin
            v_1 <= 1'b1;
            l_1 <= s_axis.last;
            d_1 <= s_axis.data;
        end else if (m_axis_1.ready) begin
            v_1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_2 <= 1'b0;
            l_2 <= 1'b0;
            d_2 <= '0;
        end else if (ld_2) begin
            v_2 <= 1'b1;
            l_2 <= s_axis.last;
            d_2 <= s_axis.data;
        end else if (m_axis_2.ready) begin
            v_2 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt_1 <= '0;
            pkt_cnt_2 <= '0;
        end else begin
            if (ld_1 && s_axis.last) begin
                pkt_cnt_1 <= pkt_cnt_1 + CNT_W'(1);
            end
            if (ld_2 && s_axis.last) begin
                pkt_cnt_2 <= pkt_cnt_2 + CNT_W'(1);
            end
        end
    end

    assign m_axis_1.valid = v_1;
    assign m_axis_1.last  = l_1;
    assign m_axis_1.data  = d_1;
    assign m_axis_2.valid = v_2;
    assign m_axis_2.last  = l_2;
    assign m_axis_2.data  = d_2;

endmodule
